pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the 5-stage pipeline latches (FD, DX, XM, MW) and the PC register. Each cycle it produces the write enables and bubble-insert (flush) strobes for every latch. It detects load-use hazards, stalls the front end while a multi-cycle mult/div runs, and squashes wrong-path instructions on a taken branch or jump. It sits beside the latches; every latch's wren and flush input is driven only from here.

Parameters:
MD_MAX_CYCLES, 40, watchdog limit on cycles spent waiting for md_ready before a forced release.
CNT_W, 32, width of the stall performance counter.

Ports:
clock  in  1  single system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-low; sampled on the rising edge of clock.
fd_instr  in  32  instruction currently held in the FD latch (decode stage).
dx_instr  in  32  instruction currently held in the DX latch (execute stage).
branch_taken_x  in  1  the instruction in X is a taken branch, jump, jal or jr.
md_ready  in  1  multdiv result ready (one-cycle pulse).
pc_wren  out  1  PC register write enable.
fd_wren  out  1  FD latch write enable.
fd_flush  out  1  FD latch clear; captures a nop.
dx_wren  out  1  DX latch write enable.
dx_flush  out  1  DX latch clear; captures a nop.
xm_wren  out  1  XM latch write enable.
xm_flush  out  1  XM latch clear; bubble while mult/div is pending.
mw_wren  out  1  MW latch write enable.
md_start_mult  out  1  one-cycle ctrl_MULT pulse.
md_start_div  out  1  one-cycle ctrl_DIV pulse.
md_timeout  out  1  sticky flag; set when the watchdog fires.
stall_count  out  CNT_W  number of cycles with pc_wren=0.

Behaviour:
- Decode fields: opcode[31:27], rd[26:22], rs[21:17], rt[16:12], aluop[6:2].
- A mult/div in X is opcode 00000 with aluop 00110 (mult) or 00111 (div).
- A load in X is opcode 01000 with rd != 0.
- Registers read by the D instruction:
  - R-type (00000): rs and rt.
  - sw (00111), bne (00010), blt (00110), jr (00100): rs and rd.
  - Other I-type: rs only.
  - j, jal, setx (00001, 00011, 10101): none.
- load_use = load in X and its rd matches any register read by the D instruction.
- FSM states: RUN, MD_WAIT. Outputs are combinational from state and inputs.
- RUN, branch_taken_x=1 (highest priority):
  - fd_flush=1, dx_flush=1; all wren=1.
  - This also squashes any load_use in the same cycle.
- RUN, load_use (branch not taken):
  - pc_wren=0, fd_wren=0, dx_flush=1; other wren=1.
  - Exactly one bubble; the next cycle re-evaluates and finds no hazard.
- RUN, mult/div in X (no branch):
  - md_start_mult or md_start_div =1 for this cycle.
  - pc_wren=fd_wren=dx_wren=0, xm_flush=1.
  - Next state MD_WAIT; wait counter cleared to 0.
- RUN, no hazard: all wren=1, all flush=0.
- MD_WAIT, md_ready=0:
  - pc_wren=fd_wren=dx_wren=0, xm_flush=1, mw_wren=1.
  - Counter increments.
  - branch_taken_x and load_use are ignored (X holds the mult/div).
- MD_WAIT, md_ready=1:
  - All wren=1, no flush; the result enters XM.
  - Next state RUN.
  - The mult/div does not restart: the FSM takes a one-cycle RUN-exit guard, and the DX contents advance in the same cycle.
- MD_WAIT watchdog: when the counter reaches MD_MAX_CYCLES-1 without md_ready:
  - Release as if md_ready=1.
  - Set md_timeout; it clears only on reset.
- md_start pulses are never asserted for two consecutive cycles.
- stall_count increments on every cycle with pc_wren=0. It wraps modulo 2^CNT_W.
- While reset=0, outputs are forced:
  - all wren=0, fd_flush=dx_flush=xm_flush=1.
  - md_start_*=0, md_timeout=0.
  - State returns to RUN; counters are cleared on the clock edge.
- Reset mid-MD_WAIT abandons the operation with no md_start pulse.

Decomposition:
- Shared package pipeline_pkg holds:
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BNE, OP_BLT, OP_JR, OP_J, OP_JAL, OP_SETX.
  - ALU op codes ALUOP_MULT, ALUOP_DIV.
  - Field bit positions.
  - State enum {RUN, MD_WAIT}.
- One sub-module, instr_src_decode: combinational; takes an instruction and returns the source-register valid bits and indices. It is reused by the bypass logic.

Test Plan:
1. Load-use: dx=lw r5, fd=add r6,r5,r2. Required: one cycle with pc_wren=0, fd_wren=0, dx_flush=1; the next cycle is all-enable. stall_count=1.
2. lw r5 then add r6,r0,r0 (no dependency): no stall. lw r0 followed by a use of r0: no stall.
3. Branch with hazard: branch_taken_x=1 while load_use would also fire. Required: fd_flush=dx_flush=1, pc_wren=1, no stall.
4. mult in X; md_ready arrives 33 cycles later. Required: md_start_mult pulse in cycle 0 only, 33 frozen cycles with xm_flush=1, release on md_ready, stall_count=34.
5. div in X with md_ready never asserted, MD_MAX_CYCLES=40. Required: forced release at cycle 40, md_timeout=1 and held.
6. reset=0 asserted during MD_WAIT. Required: outputs at their reset values in the same cycle; state RUN after the edge; md_timeout=0; stall_count=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcode/ALU-op encodings, instruction field positions,
// hazard sequencer state enum and small field-extraction helpers.
package pipeline_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 5;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned ALUOP_W = 5;

  localparam int unsigned OP_LSB    = 27;
  localparam int unsigned RD_LSB    = 22;
  localparam int unsigned RS_LSB    = 17;
  localparam int unsigned RT_LSB    = 12;
  localparam int unsigned ALUOP_LSB = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 5'b00000;
  localparam logic [OP_W-1:0] OP_J     = 5'b00001;
  localparam logic [OP_W-1:0] OP_BNE   = 5'b00010;
  localparam logic [OP_W-1:0] OP_JAL   = 5'b00011;
  localparam logic [OP_W-1:0] OP_JR    = 5'b00100;
  localparam logic [OP_W-1:0] OP_BLT   = 5'b00110;
  localparam logic [OP_W-1:0] OP_SW    = 5'b00111;
  localparam logic [OP_W-1:0] OP_LW    = 5'b01000;
  localparam logic [OP_W-1:0] OP_SETX  = 5'b10101;

  localparam logic [ALUOP_W-1:0] ALUOP_MULT = 5'b00110;
  localparam logic [ALUOP_W-1:0] ALUOP_DIV  = 5'b00111;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } md_state_e;

  function automatic logic [OP_W-1:0] get_op(input logic [INSTR_W-1:0] instr);
    return instr[OP_LSB +: OP_W];
  endfunction

  function automatic logic [REG_W-1:0] get_rd(input logic [INSTR_W-1:0] instr);
    return instr[RD_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] get_rs(input logic [INSTR_W-1:0] instr);
    return instr[RS_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] get_rt(input logic [INSTR_W-1:0] instr);
    return instr[RT_LSB +: REG_W];
  endfunction

  function automatic logic [ALUOP_W-1:0] get_aluop(input logic [INSTR_W-1:0] instr);
    return instr[ALUOP_LSB +: ALUOP_W];
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_src_decode.sv
// Source-register decoder: which registers an instruction reads and their indices.
// Shared by the hazard sequencer and the bypass logic.
module instr_src_decode
  import pipeline_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic               src1_vld,
  output logic [REG_W-1:0]   src1,
  output logic               src2_vld,
  output logic [REG_W-1:0]   src2
);

  logic [OP_W-1:0] op;
  logic            unused_imm;

  assign op         = get_op(instr);
  assign unused_imm = ^instr[RT_LSB-1:0];

  // src1 is always rs when anything is read; src2 is rt for R-type, rd for store/branch/jr
  always_comb begin
    src1_vld = 1'b1;
    src1     = get_rs(instr);
    src2_vld = 1'b0;
    src2     = get_rd(instr);
    unique case (op)
      OP_RTYPE: begin
        src2_vld = 1'b1;
        src2     = get_rt(instr);
      end
      OP_SW, OP_BNE, OP_BLT, OP_JR: begin
        src2_vld = 1'b1;
      end
      OP_J, OP_JAL, OP_SETX: begin
        src1_vld = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: latch write enables and flush strobes for PC/FD/DX/XM/MW,
// load-use stalls, mult/div front-end freeze with watchdog, and taken-branch squash.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned MD_MAX_CYCLES = 40,
  parameter int unsigned CNT_W         = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        fd_instr,
  input  logic [31:0]        dx_instr,
  input  logic               branch_taken_x,
  input  logic               md_ready,
  output logic               pc_wren,
  output logic               fd_wren,
  output logic               fd_flush,
  output logic               dx_wren,
  output logic               dx_flush,
  output logic               xm_wren,
  output logic               xm_flush,
  output logic               mw_wren,
  output logic               md_start_mult,
  output logic               md_start_div,
  output logic               md_timeout,
  output logic [CNT_W-1:0]   stall_count
);

  localparam int unsigned WD_W = (MD_MAX_CYCLES > 1) ? $clog2(MD_MAX_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MD_MAX_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic             guard_q, guard_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             fd_src1_vld, fd_src2_vld;
  logic [REG_W-1:0] fd_src1, fd_src2;
  logic [OP_W-1:0]  dx_op;
  logic [REG_W-1:0] dx_rd;
  logic [ALUOP_W-1:0] dx_aluop;
  logic             ld_in_x, load_use, mult_in_x, div_in_x, md_in_x;
  logic             unused_dx_bits;

  instr_src_decode u_fd_src (
    .instr    (fd_instr),
    .src1_vld (fd_src1_vld),
    .src1     (fd_src1),
    .src2_vld (fd_src2_vld),
    .src2     (fd_src2)
  );

  assign dx_op          = get_op(dx_instr);
  assign dx_rd          = get_rd(dx_instr);
  assign dx_aluop       = get_aluop(dx_instr);
  assign unused_dx_bits = ^{dx_instr[RD_LSB-1:ALUOP_LSB+ALUOP_W], dx_instr[ALUOP_LSB-1:0]};

  // A load writing r0 can never create a dependency
  assign ld_in_x   = (dx_op == OP_LW) && (dx_rd != '0);
  assign load_use  = ld_in_x && ((fd_src1_vld && (fd_src1 == dx_rd)) ||
                                 (fd_src2_vld && (fd_src2 == dx_rd)));
  assign mult_in_x = (dx_op == OP_RTYPE) && (dx_aluop == ALUOP_MULT);
  assign div_in_x  = (dx_op == OP_RTYPE) && (dx_aluop == ALUOP_DIV);
  assign md_in_x   = mult_in_x || div_in_x;

  always_comb begin
    state_d       = state_q;
    wd_cnt_d      = wd_cnt_q;
    guard_d       = 1'b0;
    timeout_d     = timeout_q;
    stall_cnt_d   = stall_cnt_q;
    pc_wren       = 1'b1;
    fd_wren       = 1'b1;
    fd_flush      = 1'b0;
    dx_wren       = 1'b1;
    dx_flush      = 1'b0;
    xm_wren       = 1'b1;
    xm_flush      = 1'b0;
    mw_wren       = 1'b1;
    md_start_mult = 1'b0;
    md_start_div  = 1'b0;

    unique case (state_q)
      RUN: begin
        if (branch_taken_x) begin
          fd_flush = 1'b1;
          dx_flush = 1'b1;
        end else if (load_use) begin
          pc_wren  = 1'b0;
          fd_wren  = 1'b0;
          dx_flush = 1'b1;
        end else if (md_in_x && !guard_q) begin
          // guard_q blocks a restart while the just-finished mult/div is still visible in DX
          md_start_mult = mult_in_x;
          md_start_div  = div_in_x;
          pc_wren       = 1'b0;
          fd_wren       = 1'b0;
          dx_wren       = 1'b0;
          xm_flush      = 1'b1;
          state_d       = MD_WAIT;
          wd_cnt_d      = '0;
        end
      end
      MD_WAIT: begin
        if (md_ready || (wd_cnt_q == WD_LIMIT)) begin
          state_d = RUN;
          guard_d = 1'b1;
          if (!md_ready) begin
            timeout_d = 1'b1;
          end
        end else begin
          pc_wren  = 1'b0;
          fd_wren  = 1'b0;
          dx_wren  = 1'b0;
          xm_flush = 1'b1;
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end
      default: state_d = RUN;
    endcase

    if (!pc_wren) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    // Reset overrides every strobe in the same cycle
    if (!reset) begin
      pc_wren       = 1'b0;
      fd_wren       = 1'b0;
      dx_wren       = 1'b0;
      xm_wren       = 1'b0;
      mw_wren       = 1'b0;
      fd_flush      = 1'b1;
      dx_flush      = 1'b1;
      xm_flush      = 1'b1;
      md_start_mult = 1'b0;
      md_start_div  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= RUN;
      wd_cnt_q    <= '0;
      guard_q     <= 1'b0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wd_cnt_q    <= wd_cnt_d;
      guard_q     <= guard_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign md_timeout  = reset & timeout_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

  logic        clock;
  logic        reset;
  logic [31:0] fd_instr, dx_instr;
  logic        branch_taken_x, md_ready;
  logic        pc_wren, fd_wren, fd_flush, dx_wren, dx_flush;
  logic        xm_wren, xm_flush, mw_wren, md_start_mult, md_start_div, md_timeout;
  logic [31:0] stall_count;
  logic [9:0]  ctl;

  int n_cmp = 0;
  int n_err = 0;

  // {pc_wren, fd_wren, fd_flush, dx_wren, dx_flush, xm_wren, xm_flush, mw_wren, start_mult, start_div}
  localparam logic [9:0] CTL_RUN  = 10'b1101010100;
  localparam logic [9:0] CTL_LU   = 10'b0001110100;
  localparam logic [9:0] CTL_BR   = 10'b1111110100;
  localparam logic [9:0] CTL_MULT = 10'b0000011110;
  localparam logic [9:0] CTL_DIV  = 10'b0000011101;
  localparam logic [9:0] CTL_WAIT = 10'b0000011100;
  localparam logic [9:0] CTL_RST  = 10'b0010101000;
  localparam logic [31:0] NOP = 32'h0;

  pipeline_hazard_ctrl #(.MD_MAX_CYCLES(40), .CNT_W(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .fd_instr       (fd_instr),
    .dx_instr       (dx_instr),
    .branch_taken_x (branch_taken_x),
    .md_ready       (md_ready),
    .pc_wren        (pc_wren),
    .fd_wren        (fd_wren),
    .fd_flush       (fd_flush),
    .dx_wren        (dx_wren),
    .dx_flush       (dx_flush),
    .xm_wren        (xm_wren),
    .xm_flush       (xm_flush),
    .mw_wren        (mw_wren),
    .md_start_mult  (md_start_mult),
    .md_start_div   (md_start_div),
    .md_timeout     (md_timeout),
    .stall_count    (stall_count)
  );

  assign ctl = {pc_wren, fd_wren, fd_flush, dx_wren, dx_flush,
                xm_wren, xm_flush, mw_wren, md_start_mult, md_start_div};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] r_ins(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] aluop);
    return {5'b00000, rd, rs, rt, 5'b00000, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] i_ins(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; fd_instr = NOP; dx_instr = NOP; branch_taken_x = 1'b0; md_ready = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; fd_instr = NOP; dx_instr = NOP; branch_taken_x = 1'b0; md_ready = 1'b0;
    @(negedge clock);
    n_cmp++; if (ctl !== CTL_RST) begin n_err++; $display("FAIL reset_ctl: got %b want %b", ctl, CTL_RST); end
    n_cmp++; if (md_timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", md_timeout); end
    tick();
    reset = 1'b1;
    @(negedge clock);
    n_cmp++; if (stall_count !== 32'd0) begin n_err++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_count); end
    n_cmp++; if (ctl !== CTL_RUN) begin n_err++; $display("FAIL reset_run_ctl: got %b want %b", ctl, CTL_RUN); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    dx_instr = i_ins(5'b01000, 5'd5, 5'd1, 17'd4);
    fd_instr = r_ins(5'd6, 5'd5, 5'd2, 5'd0);
    @(negedge clock);
    n_cmp++; if (ctl !== CTL_LU) begin n_err++; $display("FAIL lu_bubble: got %b want %b", ctl, CTL_LU); end
    tick();
    dx_instr = NOP;
    @(negedge clock);
    n_cmp++; if (ctl !== CTL_RUN) begin n_err++; $display("FAIL lu_after: got %b want %b", ctl, CTL_RUN); end
    n_cmp++; if (stall_count !== 32'd1) begin n_err++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_count); end
    tick();
  endtask

  task automatic test_load_use_srcs();
    logic [31:0] fds [8];
    logic [9:0]  exps [8];
    fds[0] = r_ins(5'd6, 5'd2, 5'd5, 5'd0);           exps[0] = CTL_LU;   // add rt=r5
    fds[1] = i_ins(5'b00111, 5'd5, 5'd3, 17'd0);      exps[1] = CTL_LU;   // sw rd=r5
    fds[2] = i_ins(5'b00010, 5'd5, 5'd3, 17'd0);      exps[2] = CTL_LU;   // bne rd=r5
    fds[3] = i_ins(5'b00100, 5'd5, 5'd0, 17'd0);      exps[3] = CTL_LU;   // jr rd=r5
    fds[4] = i_ins(5'b00101, 5'd7, 5'd5, 17'd1);      exps[4] = CTL_LU;   // addi rs=r5
    fds[5] = i_ins(5'b00101, 5'd5, 5'd1, 17'd1);      exps[5] = CTL_RUN;  // addi writes r5 only
    fds[6] = i_ins(5'b00001, 5'd5, 5'd5, 17'd0);      exps[6] = CTL_RUN;  // j reads nothing
    fds[7] = i_ins(5'b10101, 5'd5, 5'd5, 17'd0);      exps[7] = CTL_RUN;  // setx reads nothing
    do_reset();
    dx_instr = i_ins(5'b01000, 5'd5, 5'd1, 17'd0);
    for (int i = 0; i < 8; i++) begin
      fd_instr = fds[i];
      @(negedge clock);
      n_cmp++; if (ctl !== exps[i]) begin n_err++; $display("FAIL lu_src_%0d: got %b want %b", i, ctl, exps[i]); end
      tick();
    end
    dx_instr = NOP;
    @(negedge clock);
    n_cmp++; if (stall_count !== 32'd5) begin n_err++; $display("FAIL lu_src_stall_cnt: got %0d want 5", stall_count); end
    tick();
  endtask

  task automatic test_no_dependency();
    do_reset();
    dx_instr = i_ins(5'b01000, 5'd5, 5'd1, 17'd0);
    fd_instr = r_ins(5'd6, 5'd0, 5'd0, 5'd0);
    @(negedge clock);
    n_cmp++; if (ctl !== CTL_RUN) begin n_err++; $display("FAIL nodep_r0srcs: got %b want %b", ctl, CTL_RUN); end
    tick();
    dx_instr = i_ins(5'b01000, 5'd0, 5'd1, 17'd0);
    fd_instr = r_ins(5'd1, 5'd0, 5'd0, 5'd0);
    @(negedge clock);
    n_cmp++; if (ctl !== CTL_RUN) begin n_err++; $display("FAIL nodep_lw_r0: got %b want %b", ctl, CTL_RUN); end
    tick();
    dx_instr = NOP;
    @(negedge clock);
    n_cmp++; if (stall_count !== 32'd0) begin n_err++; $display("FAIL nodep_stall_cnt: got %0d want 0", stall_count); end
    tick();
  endtask

  task automatic test_branch_hazard();
    do_reset();
    dx_instr = i_ins(5'b01000, 5'd5, 5'd1, 17'd0);
    fd_instr = r_ins(5'd6, 5'd5, 5'd2, 5'd0);
    branch_taken_x = 1'b1;
    @(negedge clock);
    n_cmp++; if (ctl !== CTL_BR) begin n_err++; $display("FAIL br_squash: got %b want %b", ctl, CTL_BR); end
    tick();
    branch_taken_x = 1'b0; dx_instr = NOP; fd_instr = NOP;
    @(negedge clock);
    n_cmp++; if (stall_count !== 32'd0) begin n_err++; $display("FAIL br_stall_cnt: got %0d want 0", stall_count); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    dx_instr = i_ins(5'b01000, 5'd5, 5'd1, 17'd0);
    fd_instr = r_ins(5'd6, 5'd5, 5'd2, 5'd0);
    @(negedge clock);
    n_cmp++; if (ctl !== CTL_LU) begin n_err++; $display("FAIL b2b_first: got %b want %b", ctl, CTL_LU); end
    tick();
    dx_instr = i_ins(5'b01000, 5'd9, 5'd1, 17'd0);
    fd_instr = r_ins(5'd6, 5'd3, 5'd9, 5'd0);
    @(negedge clock);
    n_cmp++; if (ctl !== CTL_LU) begin n_err++; $display("FAIL b2b_second: got %b want %b", ctl, CTL_LU); end
    tick();
    dx_instr = NOP;
    @(negedge clock);
    n_cmp++; if (stall_count !== 32'd2) begin n_err++; $display("FAIL b2b_stall_cnt: got %0d want 2", stall_count); end
    tick();
  endtask

  task automatic test_mult_wait();
    int bad;
    do_reset();
    dx_instr = r_ins(5'd4, 5'd2, 5'd3, 5'b00110);
    fd_instr = r_ins(5'd7, 5'd1, 5'd1, 5'd0);
    @(negedge clock);
    n_cmp++; if (ctl !== CTL_MULT) begin n_err++; $display("FAIL mult_start: got %b want %b", ctl, CTL_MULT); end
    tick();
    bad = 0;
    for (int k = 1; k <= 33; k++) begin
      branch_taken_x = (k == 10);
      @(negedge clock);
      n_cmp++; if (ctl !== CTL_WAIT) begin n_err++; bad++; if (bad < 4) $display("FAIL mult_wait_%0d: got %b want %b", k, ctl, CTL_WAIT); end
      tick();
    end
    branch_taken_x = 1'b0;
    md_ready = 1'b1;
    @(negedge clock);
    n_cmp++; if (ctl !== CTL_RUN) begin n_err++; $display("FAIL mult_release: got %b want %b", ctl, CTL_RUN); end
    tick();
    md_ready = 1'b0;
    @(negedge clock);
    n_cmp++; if (ctl !== CTL_RUN) begin n_err++; $display("FAIL mult_no_restart: got %b want %b", ctl, CTL_RUN); end
    tick();
    dx_instr = NOP;
    @(negedge clock);
    n_cmp++; if (stall_count !== 32'd34) begin n_err++; $display("FAIL mult_stall_cnt: got %0d want 34", stall_count); end
    n_cmp++; if (md_timeout !== 1'b0) begin n_err++; $display("FAIL mult_timeout: got %b want 0", md_timeout); end
    tick();
  endtask

  task automatic test_div_timeout();
    int bad;
    do_reset();
    dx_instr = r_ins(5'd4, 5'd2, 5'd3, 5'b00111);
    fd_instr = NOP;
    @(negedge clock);
    n_cmp++; if (ctl !== CTL_DIV) begin n_err++; $display("FAIL div_start: got %b want %b", ctl, CTL_DIV); end
    tick();
    bad = 0;
    for (int k = 1; k <= 39; k++) begin
      @(negedge clock);
      n_cmp++; if ({ctl, md_timeout} !== {CTL_WAIT, 1'b0}) begin
        n_err++; bad++;
        if (bad < 4) $display("FAIL div_wait_%0d: got %b/%b want %b/0", k, ctl, md_timeout, CTL_WAIT);
      end
      tick();
    end
    @(negedge clock);
    n_cmp++; if (ctl !== CTL_RUN) begin n_err++; $display("FAIL div_forced_release: got %b want %b", ctl, CTL_RUN); end
    tick();
    dx_instr = NOP;
    @(negedge clock);
    n_cmp++; if (md_timeout !== 1'b1) begin n_err++; $display("FAIL div_timeout_set: got %b want 1", md_timeout); end
    n_cmp++; if (stall_count !== 32'd40) begin n_err++; $display("FAIL div_stall_cnt: got %0d want 40", stall_count); end
    for (int k = 0; k < 5; k++) tick();
    @(negedge clock);
    n_cmp++; if (md_timeout !== 1'b1) begin n_err++; $display("FAIL div_timeout_held: got %b want 1", md_timeout); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    dx_instr = r_ins(5'd4, 5'd2, 5'd3, 5'b00110);
    @(negedge clock);
    n_cmp++; if (ctl !== CTL_MULT) begin n_err++; $display("FAIL rmw_start: got %b want %b", ctl, CTL_MULT); end
    tick();
    tick();
    tick();
    @(negedge clock);
    n_cmp++; if ({ctl, md_timeout} !== {CTL_WAIT, 1'b1}) begin n_err++; $display("FAIL rmw_waiting: got %b/%b want %b/1", ctl, md_timeout, CTL_WAIT); end
    reset = 1'b0;
    #1;
    n_cmp++; if ({ctl, md_timeout} !== {CTL_RST, 1'b0}) begin n_err++; $display("FAIL rmw_reset_outs: got %b/%b want %b/0", ctl, md_timeout, CTL_RST); end
    tick();
    reset = 1'b1;
    dx_instr = NOP;
    @(negedge clock);
    n_cmp++; if (ctl !== CTL_RUN) begin n_err++; $display("FAIL rmw_state_run: got %b want %b", ctl, CTL_RUN); end
    n_cmp++; if (stall_count !== 32'd0) begin n_err++; $display("FAIL rmw_stall_cnt: got %0d want 0", stall_count); end
    n_cmp++; if (md_timeout !== 1'b0) begin n_err++; $display("FAIL rmw_timeout: got %b want 0", md_timeout); end
    tick();
  endtask

  initial begin
    reset = 1'b0; fd_instr = NOP; dx_instr = NOP; branch_taken_x = 1'b0; md_ready = 1'b0;
    test_reset();
    test_load_use();
    test_load_use_srcs();
    test_no_dependency();
    test_branch_hazard();
    test_back_to_back();
    test_mult_wait();
    test_div_timeout();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
